// File: rtl/ped_control_pkg.sv
// Shared traffic-light constants for the pedestrian crossing controller:
// FSM state encoding, default phase lengths and phase-counter width.
package ped_control_pkg;

  // Pedestrian lamp phases.
  typedef enum logic [1:0] {
    PED_DONT  = 2'd0,
    PED_WALK  = 2'd1,
    PED_FLASH = 2'd2
  } ped_state_e;

  // Default phase lengths, in upstream tick pulses.
  localparam int PED_WALK_TICKS_DEFAULT  = 5;
  localparam int PED_FLASH_TICKS_DEFAULT = 4;

  // Phase counter width; legal tick counts are 1..63, so it never wraps.
  localparam int PED_CNT_W = 6;

  // Count value present while the last tick of a phase is awaited.
  function automatic logic [PED_CNT_W-1:0] ped_last_count(input int ticks);
    return PED_CNT_W'(ticks - 1);
  endfunction

endpackage

// File: rtl/ped_phase_counter.sv
// Tick-enabled phase counter with synchronous clear and a terminal-count
// flag that is high while the count equals the supplied last value.
module ped_phase_counter
  import ped_control_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic [PED_CNT_W-1:0] last,
  output logic [PED_CNT_W-1:0] count,
  output logic                 tc
);

  logic [PED_CNT_W-1:0] count_d;
  logic [PED_CNT_W-1:0] count_q;

  // Clear wins over increment so a phase always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + PED_CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == last);

endmodule

// File: rtl/ped_control.sv
// Pedestrian crossing controller sitting downstream of the vehicle-light
// controller. Grants WALK only at the start of a red phase when a request is
// waiting, then a blinking clearance phase, then back to DONT.
module ped_control
  import ped_control_pkg::*;
#(
  parameter int WALK_TICKS  = PED_WALK_TICKS_DEFAULT,
  parameter int FLASH_TICKS = PED_FLASH_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic red,
  input  logic yellow,
  input  logic green,
  input  logic ped_req,
  output logic walk,
  output logic dont,
  output logic flash,
  output logic req_pending
);

  localparam logic [PED_CNT_W-1:0] WALK_LAST  = ped_last_count(WALK_TICKS);
  localparam logic [PED_CNT_W-1:0] FLASH_LAST = ped_last_count(FLASH_TICKS);

  ped_state_e state_d, state_q;
  logic       req_pending_d, req_pending_q;
  logic       red_d, red_q;
  logic       red_armed_d, red_armed_q;
  logic       blink_d, blink_q;
  logic       walk_d, walk_q;
  logic       dont_d, dont_q;
  logic       flash_d, flash_q;

  logic                 red_rise;
  logic                 phase_clr;
  logic                 phase_en;
  logic [PED_CNT_W-1:0] phase_last;
  logic [PED_CNT_W-1:0] phase_count;
  logic                 phase_tc;

  // Yellow and green are accepted for completeness but never influence the
  // crossing: only red gates pedestrian entry.
  logic lights_unused;
  assign lights_unused = yellow | green;

  // A red rise only counts once red has been seen low since reset, so a red
  // phase already in progress at reset release cannot open the crossing.
  assign red_rise = red & ~red_q & red_armed_q;

  ped_phase_counter u_phase_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (phase_clr),
    .en    (phase_en),
    .last  (phase_last),
    .count (phase_count),
    .tc    (phase_tc)
  );

  // Counter clears on every state entry and only runs inside WALK/FLASH.
  always_comb begin
    phase_clr  = (state_d != state_q);
    phase_en   = tick & (state_q != PED_DONT);
    phase_last = (state_q == PED_WALK) ? WALK_LAST : FLASH_LAST;
  end

  // Next-state, request latch, blink and output decode.
  always_comb begin
    state_d       = state_q;
    req_pending_d = req_pending_q;
    blink_d       = blink_q;
    red_d         = red;
    red_armed_d   = red_armed_q | ~red;

    case (state_q)
      PED_DONT: begin
        blink_d = 1'b0;
        if (red_rise && (req_pending_q || ped_req)) begin
          // Entering WALK serves the request; a simultaneous ped_req is absorbed.
          state_d       = PED_WALK;
          req_pending_d = 1'b0;
        end else if (ped_req) begin
          req_pending_d = 1'b1;
        end
      end
      PED_WALK: begin
        // Requests are ignored while the walk lamp is lit.
        if (!red) begin
          state_d = PED_DONT;
        end else if (tick && phase_tc) begin
          state_d = PED_FLASH;
          blink_d = 1'b1;
        end
      end
      PED_FLASH: begin
        if (ped_req) begin
          req_pending_d = 1'b1;
        end
        if (!red) begin
          state_d = PED_DONT;
          blink_d = 1'b0;
        end else if (tick) begin
          if (phase_tc) begin
            state_d = PED_DONT;
            blink_d = 1'b0;
          end else begin
            blink_d = ~blink_q;
          end
        end
      end
      default: begin
        state_d = PED_DONT;
        blink_d = 1'b0;
      end
    endcase

    // Lamps are decoded from the next state so they are registered with it.
    walk_d  = (state_d == PED_WALK);
    flash_d = (state_d == PED_FLASH);
    dont_d  = (state_d == PED_DONT) | ((state_d == PED_FLASH) & blink_d);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= PED_DONT;
      req_pending_q <= 1'b0;
      red_q         <= 1'b0;
      red_armed_q   <= 1'b0;
      blink_q       <= 1'b0;
      walk_q        <= 1'b0;
      dont_q        <= 1'b1;
      flash_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_pending_q <= req_pending_d;
      red_q         <= red_d;
      red_armed_q   <= red_armed_d;
      blink_q       <= blink_d;
      walk_q        <= walk_d;
      dont_q        <= dont_d;
      flash_q       <= flash_d;
    end
  end

  assign walk        = walk_q;
  assign dont        = dont_q;
  assign flash       = flash_q;
  assign req_pending = req_pending_q;

endmodule

// File: tb/tb_ped_control.sv
// Self-checking bench for ped_control: two instances (default lengths and
// 1/1 lengths) share stimulus; a countdown-based reference model predicts
// every lamp each cycle. Directed scenarios first, then randomized traffic.
module tb_ped_control;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0, red = 1'b0, yellow = 1'b0, green = 1'b0, ped_req = 1'b0;
  logic [1:0] walk, dont, flash, pend;

  always #5 clk = ~clk;

  ped_control #(.WALK_TICKS(5), .FLASH_TICKS(4)) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .red(red), .yellow(yellow),
    .green(green), .ped_req(ped_req), .walk(walk[0]), .dont(dont[0]),
    .flash(flash[0]), .req_pending(pend[0])
  );

  ped_control #(.WALK_TICKS(1), .FLASH_TICKS(1)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .red(red), .yellow(yellow),
    .green(green), .ped_req(ped_req), .walk(walk[1]), .dont(dont[1]),
    .flash(flash[1]), .req_pending(pend[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: mode 0=don't walk, 1=walk, 2=flash; 'left' counts the
  // ticks still owed to the current phase, 'fl' counts ticks spent in flash.
  int wt[2] = '{5, 1};
  int ft[2] = '{4, 1};
  int m_mode[2];
  int m_left[2];
  int m_fl[2];
  bit m_pend[2];
  bit m_prev_red[2];
  bit m_seen_low[2];

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_mode[k] = 0; m_left[k] = 0; m_fl[k] = 0;
        m_pend[k] = 0; m_prev_red[k] = 0; m_seen_low[k] = 0;
      end else begin
        int  old_mode;
        bit  rise;
        bit  enter;
        old_mode = m_mode[k];
        rise     = red && !m_prev_red[k] && m_seen_low[k];
        enter    = 0;
        if (old_mode != 0 && !red) begin
          m_mode[k] = 0;
        end else if (old_mode == 0) begin
          if (rise && (m_pend[k] || ped_req)) begin
            m_mode[k] = 1; m_left[k] = wt[k]; enter = 1;
          end
        end else if (old_mode == 1) begin
          if (tick) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
              m_mode[k] = 2; m_left[k] = ft[k]; m_fl[k] = 0;
            end
          end
        end else begin
          if (tick) begin
            m_left[k]--; m_fl[k]++;
            if (m_left[k] == 0) m_mode[k] = 0;
          end
        end
        if (enter) m_pend[k] = 0;
        else if (old_mode != 1 && ped_req) m_pend[k] = 1;
        m_prev_red[k] = red;
        if (!red) m_seen_low[k] = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("walk[%0d]", k),  walk[k],  m_mode[k] == 1);
      check($sformatf("flash[%0d]", k), flash[k], m_mode[k] == 2);
      check($sformatf("dont[%0d]", k),  dont[k],
            (m_mode[k] == 0) || (m_mode[k] == 2 && (m_fl[k] % 2) == 0));
      check($sformatf("req_pending[%0d]", k), pend[k], m_pend[k]);
    end
  endtask

  // One clock cycle: drive at the falling edge, model at the rising edge,
  // compare at the next falling edge.
  task automatic step(input bit t, input bit r, input bit y, input bit g,
                      input bit p, input bit rs);
    tick = t; red = r; yellow = y; green = g; ped_req = p; reset = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    cyc++;
  endtask

  task automatic run(input int n, input bit r, input bit y, input bit g, input bit p);
    for (int i = 0; i < n; i++) begin
      step((cyc % 3) == 0, r, y, g, p, 1'b1);
    end
  endtask

  initial begin
    int len;
    bit r, y, g, p, t, rs;

    @(negedge clk);

    // Reset state
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("reset_dont", dont[0], 1'b1);
    check("reset_walk", walk[0], 1'b0);
    check("reset_flash", flash[0], 1'b0);
    check("reset_pend", pend[0], 1'b0);

    // Normal cycle: request during green, walk one cycle after red rise
    run(4, 0, 0, 1, 0);
    run(1, 0, 0, 1, 1);
    check("pend_after_green_req", pend[0], 1'b1);
    run(3, 0, 1, 0, 0);
    run(1, 1, 0, 0, 0);
    check("walk_after_rise", walk[0], 1'b1);
    check("pend_cleared_on_walk", pend[0], 1'b0);
    run(39, 1, 0, 0, 0);
    check("normal_back_to_dont", dont[0], 1'b1);

    // Late request mid-red waits for the next red rise
    run(5, 0, 0, 1, 0);
    run(6, 1, 0, 0, 0);
    run(1, 1, 0, 0, 1);
    run(5, 1, 0, 0, 0);
    check("late_req_pending", pend[0], 1'b1);
    check("late_req_no_walk", walk[0], 1'b0);
    run(3, 0, 0, 1, 0);
    run(1, 1, 0, 0, 0);
    check("late_req_walk", walk[0], 1'b1);
    run(39, 1, 0, 0, 0);

    // Safety abort: red drops during WALK
    run(3, 0, 0, 1, 1);
    run(1, 1, 0, 0, 0);
    run(6, 1, 0, 0, 0);
    check("abort_pre_walk", walk[0], 1'b1);
    run(1, 0, 0, 1, 0);
    check("abort_walk", walk[0], 1'b0);
    check("abort_dont", dont[0], 1'b1);

    // Request coincident with red rise, held through WALK
    run(3, 0, 0, 1, 0);
    run(1, 1, 0, 0, 1);
    check("simul_walk", walk[0], 1'b1);
    check("simul_pend", pend[0], 1'b0);
    run(10, 1, 0, 0, 1);
    check("held_req_in_walk", pend[0], 1'b0);
    run(20, 1, 0, 0, 1);
    check("held_req_after_walk", pend[0], 1'b1);

    // Reset mid-WALK, then release with red already high
    run(3, 0, 0, 1, 1);
    run(3, 1, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_walk_dont", dont[0], 1'b1);
    check("rst_walk_walk", walk[0], 1'b0);
    check("rst_walk_flash", flash[0], 1'b0);
    check("rst_walk_pend", pend[0], 1'b0);
    run(5, 1, 0, 0, 1);
    check("no_rise_after_reset", walk[0], 1'b0);
    run(2, 0, 0, 1, 0);
    run(1, 1, 0, 0, 0);
    check("rise_after_refall", walk[0], 1'b1);

    // Randomized traffic: green/yellow/red phases with glitches and resets
    for (int s = 0; s < 150; s++) begin
      len = $urandom_range(3, 40);
      for (int i = 0; i < len; i++) begin
        r = (s % 3) == 2;
        g = (s % 3) == 0;
        y = (s % 3) == 1;
        if (r && $urandom_range(0, 60) == 0) r = 1'b0;
        if (r && $urandom_range(0, 15) == 0) begin y = 1'b1; g = 1'b1; end
        t  = $urandom_range(0, 2) == 0;
        p  = $urandom_range(0, 9) == 0;
        rs = $urandom_range(0, 400) != 0;
        step(t, r, y, g, p, rs);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ped_control.md
PED_CONTROL -- requirements
Module: ped_control

Interface
REQ-001 Parameter WALK_TICKS, default 5, sets the number of tick pulses spent in WALK.
REQ-002 Parameter FLASH_TICKS, default 4, sets the number of tick pulses spent in FLASH.
REQ-003 Port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 Port tick, input, 1 bit, one-cycle enable pulse at the phase rate from the upstream divider.
REQ-006 Ports red, yellow and green, inputs, 1 bit each, vehicle-light outputs of the traffic-light controller.
REQ-007 Port ped_req, input, 1 bit, synchronous pedestrian request, level or pulse.
REQ-008 Port walk, output, 1 bit, walk lamp.
REQ-009 Port dont, output, 1 bit, don't-walk lamp.
REQ-010 Port flash, output, 1 bit, high while in the clearance (flashing) phase.
REQ-011 Port req_pending, output, 1 bit, latched unserved request.

Function
REQ-012 The FSM SHALL have states DONT, WALK and FLASH; all outputs SHALL be registered.
REQ-013 A registered copy red_q SHALL define red_rise = red and not red_q.
REQ-014 In DONT and FLASH, ped_req=1 SHALL set req_pending on the next edge; in WALK, ped_req SHALL be ignored.
REQ-015 DONT->WALK SHALL occur on the edge where red_rise=1 and (req_pending=1 or ped_req=1); walk=1 is visible one cycle after that red rise.
REQ-016 A request arriving while red is already high SHALL wait for the next red_rise, so there is no mid-red entry.
REQ-017 req_pending SHALL clear on the edge entering WALK; a ped_req on that same edge SHALL be absorbed, not re-latched.
REQ-018 A 6-bit phase count SHALL clear on every state entry and increment on each tick.
REQ-019 WALK->FLASH SHALL occur on the edge where tick=1 and count = WALK_TICKS-1.
REQ-020 FLASH->DONT SHALL occur on the edge where tick=1 and count = FLASH_TICKS-1.
REQ-021 In WALK, the SHALL be walk=1, dont=0, flash=0.
REQ-022 In FLASH, the outputs SHALL be walk=0 and flash=1; blink SHALL be 1 on entry and toggle on each tick; dont SHALL equal blink.
REQ-023 In DONT, the outputs SHALL be walk=0, dont=1, flash=0.
REQ-024 Safety: if red=0 while in WALK or FLASH, the state SHALL go to DONT on the next edge, overriding tick and count.
REQ-025 Yellow and green SHALL never cause WALK; red, yellow and green high simultaneously SHALL be treated by red alone.
REQ-026 tick while in DONT SHALL leave count unchanged.
REQ-027 Parameters below 1 or above 63 are unsupported; the 6-bit count SHALL never wrap in a legal configuration.

Reset
REQ-028 reset=0 SHALL asynchronously force state DONT, dont=1, walk=0, flash=0, req_pending=0, count=0, blink=0 and red_q=0.
REQ-029 Reset asserted mid-WALK or mid-FLASH SHALL abort the phase with no residual request.
REQ-030 After deassertion, red already high SHALL not produce red_rise until red falls and rises again.

Structure
REQ-031 The state encoding and the default WALK_TICKS/FLASH_TICKS values SHALL live in the shared traffic-light constants package/include.
REQ-032 One sub-module, ped_phase_counter, SHALL implement the counter: tick-enabled, synchronous clear, terminal-count flag for a supplied limit.
REQ-033 The block SHALL sit downstream of the traffic-light controller, consuming red/yellow/green unmodified.

Verification
REQ-034 Reset test: reset=0 mid-WALK -> next sample shows dont=1, walk=0, flash=0, req_pending=0.
REQ-035 Normal cycle: ped_req pulse during green, then red rises -> walk=1 one cycle later for exactly 5 ticks, then flash=1 with dont toggling 1,0,1,0 over 4 ticks, then DONT.
REQ-036 Late request: ped_req pulse mid-red -> req_pending=1 and walk stays 0 until the next red rise, then WALK.
REQ-037 Safety abort: red drops after 2 ticks of WALK -> DONT next edge with walk=0 and dont=1.
REQ-038 Simultaneous events: ped_req and red_rise in the same cycle -> WALK entry with req_pending=0; ped_req held through WALK -> req_pending stays 0 until FLASH.
REQ-039 Parameter edge: WALK_TICKS=1, FLASH_TICKS=1 -> WALK for 1 tick, FLASH for 1 tick with dont=1, then DONT.
